// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Receives a program image as a byte stream (valid/ready), packs
//            little-endian 32-bit words into instruction memory starting at
//            word address 0, verifies an XOR checksum and only then releases
//            the core from reset.
//            Stream format: N[7:0], N[15:8], 4*N data bytes (LSB first per
//            word), one checksum byte = XOR of all data bytes.
// Ports    : clk, rst_n        - clock, synchronous active-low reset
//            s_valid/s_data    - byte stream in
//            s_ready           - loader can accept a byte
//            imem_we/waddr/wdata - one-cycle imem word write
//            core_rst_n        - active-low reset to the core, high once loaded
//            boot_done         - sticky, image loaded and checksum good
//            boot_error        - sticky, length or checksum error
//            word_count        - words written so far
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              boot_done,
    output logic              boot_error,
    output logic [15:0]       word_count
);

    localparam logic [2:0] c_hdr_lo = 3'd0;
    localparam logic [2:0] c_hdr_hi = 3'd1;
    localparam logic [2:0] c_data   = 3'd2;
    localparam logic [2:0] c_csum   = 3'd3;
    localparam logic [2:0] c_done   = 3'd4;
    localparam logic [2:0] c_error  = 3'd5;

    // One extra bit so a 16-bit header can never alias below the depth.
    localparam logic [16:0] c_depth = 17'(DEPTH_WORDS);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic [15:0]       r_len;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_csum;
    logic [23:0]       r_word;       // lanes 0..2; lane 3 comes straight from s_data
    logic [15:0]       r_word_count;

    logic              r_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_waddr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_rst_n;
    logic              r_boot_done;
    logic              r_boot_error;

    logic              w_xfer;
    logic [15:0]       w_hdr_n;
    logic              w_hdr_too_big;
    logic              w_last_byte_of_word;
    logic              w_last_word;

    logic              w_ready_nxt;
    logic              w_we_nxt;
    logic              w_done_nxt;
    logic              w_error_nxt;

    assign w_xfer              = s_valid && r_ready;
    assign w_hdr_n             = {s_data, r_len[7:0]};
    assign w_hdr_too_big       = ({1'b0, w_hdr_n} > c_depth);
    assign w_last_byte_of_word = (r_byte_idx == 2'd3);
    // word_count has already been bumped for every completed earlier word by
    // the time the last byte of the next word arrives (>= 4 cycles later).
    assign w_last_word         = (r_word_count == (r_len - 16'd1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_hdr_lo;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_hdr_lo: begin
                if (w_xfer) w_state_nxt = c_hdr_hi;
            end
            c_hdr_hi: begin
                if (w_xfer) begin
                    if (w_hdr_too_big)          w_state_nxt = c_error;
                    else if (w_hdr_n == 16'd0)  w_state_nxt = c_csum;
                    else                        w_state_nxt = c_data;
                end
            end
            c_data: begin
                if (w_xfer && w_last_byte_of_word && w_last_word) w_state_nxt = c_csum;
            end
            c_csum: begin
                if (w_xfer) w_state_nxt = (s_data == r_csum) ? c_done : c_error;
            end
            c_done:  w_state_nxt = c_done;
            c_error: w_state_nxt = c_error;
            default: w_state_nxt = c_hdr_lo;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode; every output is registered from these next values so
    // the flags line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        w_ready_nxt = (w_state_nxt == c_hdr_lo) || (w_state_nxt == c_hdr_hi) ||
                      (w_state_nxt == c_data)   || (w_state_nxt == c_csum);
        w_done_nxt  = (w_state_nxt == c_done);
        w_error_nxt = (w_state_nxt == c_error);
        w_we_nxt    = (r_state == c_data) && w_xfer && w_last_byte_of_word;
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len        <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_csum       <= 8'h00;
            r_word       <= 24'd0;
            r_word_count <= 16'd0;
            r_ready      <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= 32'd0;
            r_core_rst_n <= 1'b0;
            r_boot_done  <= 1'b0;
            r_boot_error <= 1'b0;
        end else begin
            r_ready      <= w_ready_nxt;
            r_imem_we    <= w_we_nxt;
            r_core_rst_n <= w_done_nxt;
            r_boot_done  <= w_done_nxt;
            r_boot_error <= w_error_nxt;

            if (w_xfer && (r_state == c_hdr_lo)) begin
                r_len[7:0] <= s_data;
            end
            if (w_xfer && (r_state == c_hdr_hi)) begin
                r_len[15:8] <= s_data;
            end

            if (w_xfer && (r_state == c_data)) begin
                r_csum     <= r_csum ^ s_data;
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_word[7:0]   <= s_data;
                    2'd1: r_word[15:8]  <= s_data;
                    2'd2: r_word[23:16] <= s_data;
                    default: begin
                        // Word complete: present it next cycle and bump the
                        // count in that same cycle. N <= DEPTH_WORDS keeps the
                        // address inside memory, so no wrap can occur.
                        r_imem_wdata <= {s_data, r_word};
                        r_imem_waddr <= r_word_count[ADDR_W-1:0];
                        r_word_count <= r_word_count + 16'd1;
                    end
                endcase
            end
        end
    end

    assign s_ready    = r_ready;
    assign imem_we    = r_imem_we;
    assign imem_waddr = r_imem_waddr;
    assign imem_wdata = r_imem_wdata;
    assign core_rst_n = r_core_rst_n;
    assign boot_done  = r_boot_done;
    assign boot_error = r_boot_error;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Directed self-checking bench for imem_boot_loader. Streams
//            hand-built images and compares flags and the captured imem
//            write sequence against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int DEPTH_WORDS = 1024;
    localparam int ADDR_W      = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              boot_done;
    logic              boot_error;
    logic [15:0]       word_count;

    always #5 clk = ~clk;

    imem_boot_loader #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n),
        .boot_done (boot_done),
        .boot_error(boot_error),
        .word_count(word_count)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [15:0]       wc;
    } wr_t;

    wr_t wq[$];
    int  n_checks = 0;
    int  n_errors = 0;

    // Capture every write pulse away from the active edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) wq.push_back('{imem_waddr, imem_wdata, word_count});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_data  = 8'h00;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Present one byte and hold it until it transfers; returns the number of
    // cycles spent waiting on s_ready. Leaves s_valid high for back-to-back use.
    task automatic send_byte(input logic [7:0] b, input bit gappy, output int waits);
        bit timed_out;
        waits     = 0;
        timed_out = 1'b0;
        if (gappy) begin
            while ($urandom_range(1, 0) == 1) begin
                s_valid = 1'b0;
                s_data  = 8'hxx;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && !timed_out) begin
            @(posedge clk);
            #1;
            waits++;
            if (waits >= 100) timed_out = 1'b1;
        end
        if (timed_out) begin
            check("ready_timeout", {31'd0, timed_out}, 32'd0);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stream a whole image; stall_after_first counts waits after byte 0.
    task automatic send_stream(input logic [7:0] bytes[$], input bit gappy,
                               output int stall_after_first);
        int w;
        stall_after_first = 0;
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], gappy, w);
            if (i > 0) stall_after_first += w;
        end
        s_valid = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic check_t1_writes(input string tag);
        check({tag, "_nwr"}, 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check({tag, "_a0"},  32'(wq[0].addr), 32'd0);
            check({tag, "_d0"},  wq[0].data,      32'h00500093);
            check({tag, "_wc0"}, 32'(wq[0].wc),   32'd1);
            check({tag, "_a1"},  32'(wq[1].addr), 32'd1);
            check({tag, "_d1"},  wq[1].data,      32'h00700113);
            check({tag, "_wc1"}, 32'(wq[1].wc),   32'd2);
        end
    endtask

    logic [7:0] t1[$];
    logic [7:0] t2[$];
    logic [7:0] big[$];

    initial begin
        int stalls;
        int bad;
        logic [7:0] csum;

        t1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'h70, 8'h00, 8'hA1};
        t2 = t1;
        t2[10] = 8'hA0;

        // ---------------- reset state ----------------
        s_valid = 1'b0;
        s_data  = 8'h00;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, s_ready},    32'd0);
        check("rst_we",    {31'd0, imem_we},    32'd0);
        check("rst_waddr", 32'(imem_waddr),     32'd0);
        check("rst_wdata", imem_wdata,          32'd0);
        check("rst_core",  {31'd0, core_rst_n}, 32'd0);
        check("rst_done",  {31'd0, boot_done},  32'd0);
        check("rst_err",   {31'd0, boot_error}, 32'd0);
        check("rst_wc",    32'(word_count),     32'd0);
        rst_n = 1'b1;

        // ---------------- test 1: N=2 full rate ----------------
        wq.delete();
        send_stream(t1, 1'b0, stalls);
        check("t1_no_bubbles", 32'(stalls),          32'd0);
        check("t1_done",       {31'd0, boot_done},   32'd1);
        check("t1_core",       {31'd0, core_rst_n},  32'd1);
        check("t1_err",        {31'd0, boot_error},  32'd0);
        check("t1_wc",         32'(word_count),      32'd2);
        check("t1_ready",      {31'd0, s_ready},     32'd0);
        // Extra offered bytes in DONE must be ignored.
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("t1_sticky_done", {31'd0, boot_done}, 32'd1);
        check_t1_writes("t1");

        // ---------------- test 2: bad checksum ----------------
        do_reset();
        wq.delete();
        send_stream(t2, 1'b0, stalls);
        check("t2_err",   {31'd0, boot_error}, 32'd1);
        check("t2_done",  {31'd0, boot_done},  32'd0);
        check("t2_core",  {31'd0, core_rst_n}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t2_ready", {31'd0, s_ready},    32'd0);
        check("t2_sticky_err", {31'd0, boot_error}, 32'd1);
        check_t1_writes("t2");

        // ---------------- test 3: N = DEPTH+1 ----------------
        do_reset();
        wq.delete();
        send_stream('{8'h01, 8'h04}, 1'b0, stalls);
        check("t3_err",   {31'd0, boot_error}, 32'd1);
        check("t3_ready", {31'd0, s_ready},    32'd0);
        check("t3_core",  {31'd0, core_rst_n}, 32'd0);
        s_valid = 1'b1;
        s_data  = 8'h13;
        repeat (6) @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("t3_nwr",   32'(wq.size()),      32'd0);
        check("t3_wc",    32'(word_count),     32'd0);

        // ---------------- test 4: empty image ----------------
        do_reset();
        wq.delete();
        send_stream('{8'h00, 8'h00, 8'h00}, 1'b0, stalls);
        check("t4_done",  {31'd0, boot_done},  32'd1);
        check("t4_core",  {31'd0, core_rst_n}, 32'd1);
        check("t4_wc",    32'(word_count),     32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t4_nwr",   32'(wq.size()),      32'd0);

        // ---------------- test 5: gappy valid ----------------
        do_reset();
        wq.delete();
        send_stream(t1, 1'b1, stalls);
        check("t5_done",  {31'd0, boot_done},  32'd1);
        check("t5_core",  {31'd0, core_rst_n}, 32'd1);
        check("t5_err",   {31'd0, boot_error}, 32'd0);
        check("t5_wc",    32'(word_count),     32'd2);
        repeat (2) @(posedge clk);
        #1;
        check_t1_writes("t5");

        // ---------------- test 6: reset mid-load ----------------
        do_reset();
        wq.delete();
        for (int i = 0; i < 5; i++) begin
            int w;
            send_byte(t1[i], 1'b0, w);
        end
        s_valid = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_rst_wc",   32'(word_count),     32'd0);
        check("t6_rst_core", {31'd0, core_rst_n}, 32'd0);
        check("t6_rst_rdy",  {31'd0, s_ready},    32'd0);
        send_stream(t1, 1'b0, stalls);
        check("t6_done",  {31'd0, boot_done}, 32'd1);
        check("t6_wc",    32'(word_count),    32'd2);
        repeat (2) @(posedge clk);
        #1;
        check_t1_writes("t6");

        // ---------------- N == DEPTH_WORDS boundary ----------------
        do_reset();
        wq.delete();
        big.delete();
        big.push_back(8'h00);
        big.push_back(8'h04);
        csum = 8'h00;
        for (int k = 0; k < 4 * DEPTH_WORDS; k++) begin
            big.push_back(8'(k));
            csum ^= 8'(k);
        end
        big.push_back(csum);
        send_stream(big, 1'b0, stalls);
        check("big_no_bubbles", 32'(stalls),         32'd0);
        check("big_done",       {31'd0, boot_done},  32'd1);
        check("big_wc",         32'(word_count),     32'd1024);
        repeat (2) @(posedge clk);
        #1;
        check("big_nwr", 32'(wq.size()), 32'd1024);
        if (wq.size() == 1024) begin
            bad = 0;
            for (int i = 0; i < 1024; i++) begin
                logic [31:0] exp_w;
                exp_w = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
                if (wq[i].addr != ADDR_W'(i) || wq[i].data != exp_w) bad++;
            end
            check("big_seq_bad", 32'(bad),            32'd0);
            check("big_last_a",  32'(wq[1023].addr),  32'd1023);
            check("big_last_d",  wq[1023].data,       32'hFFFEFDFC);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0x00000001 expected 0x00000000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
